// File: rtl/led_pattern_monitor.sv
// -----------------------------------------------------------------------------
// led_pattern_monitor
//
// Static-region monitor for the LED bus driven by a reconfigurable partition.
// It works out which one-hot rotating pattern is loaded (shift-right or
// shift-left, both wrapping). It reports lock, direction, stall and a sticky
// fault, so the ICAP controller can confirm that a partial reconfiguration
// took effect.
//
// Optional feature (compile-time macro):
//   LED_MON_GLITCH_FILTER_EN - when defined, a changed synchronized LED value
//   must hold for FILTER_CYCLES consecutive cycles before it is evaluated.
//   Shorter pulses are discarded. Latency grows from 3 to 3+FILTER_CYCLES.
//   When undefined, no filter logic exists.
//
// Parameters:
//   WIDTH         LED bus width (3..16)
//   LOCK_STEPS    consecutive same-direction steps needed to lock
//   TICK_TIMEOUT  cycles without an LED change while locked before stall
//   FILTER_CYCLES stability cycles for the optional glitch filter
//
// Ports:
//   sys_clk_i    system clock
//   sys_rst_n_i  asynchronous active-low reset
//   led_in_i     LED bus from the RP (asynchronous, may glitch during PR)
//   decouple_i   high while PR is in progress; forces IDLE
//   locked_o     direction confirmed (also held during stall)
//   dir_right_o  locked to shift-right
//   dir_left_o   locked to shift-left
//   stalled_o    locked pattern stopped changing
//   fault_o      sticky illegal value / broken sequence
//   pos_o        index of the lit bit of the last accepted value
//   step_cnt_o   accepted steps since lock, saturating
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for the first legal (one-hot) value
// S_TRACK  | counting consecutive same-direction steps toward lock
// S_LOCKED | direction confirmed, pattern advancing
// S_STALL  | locked, but no LED change for TICK_TIMEOUT cycles
// S_FAULT  | illegal value or broken sequence; sticky until decouple/reset

module led_pattern_monitor #(
    parameter int WIDTH         = 16,
    parameter int LOCK_STEPS    = 4,
    parameter int TICK_TIMEOUT  = 15_000_000,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_n_i,
    input  logic [WIDTH-1:0] led_in_i,
    input  logic             decouple_i,
    output logic             locked_o,
    output logic             dir_right_o,
    output logic             dir_left_o,
    output logic             stalled_o,
    output logic             fault_o,
    output logic [3:0]       pos_o,
    output logic [15:0]      step_cnt_o
);

    if (WIDTH < 3 || WIDTH > 16 || LOCK_STEPS < 1 || TICK_TIMEOUT < 1 || FILTER_CYCLES < 1)
    begin : g_param_check
        $error("led_pattern_monitor: parameter out of range");
    end

    localparam int RUN_W = $clog2(LOCK_STEPS + 1);
    localparam int TMO_W = $clog2(TICK_TIMEOUT + 1);

    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_STEPS);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TICK_TIMEOUT);
    localparam logic [WIDTH-1:0] LED_LSB  = WIDTH'(1);
    localparam logic [WIDTH-1:0] LED_MSB  = LED_LSB << (WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_LOCKED,
        S_STALL,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        C_NONE,
        C_RIGHT,
        C_LEFT
    } cand_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous LED bus
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= led_in_i;
            sync2_q <= sync1_q;
        end
    end

    // Value presented to the FSM for evaluation
    logic [WIDTH-1:0] eval_val;

`ifdef LED_MON_GLITCH_FILTER_EN
    // -------------------------------------------------------------------------
    // Glitch filter: a value differing from the filtered one is adopted only
    // after it has been seen unchanged for FILTER_CYCLES cycles in a row.
    // -------------------------------------------------------------------------
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FCNT_DONE = FW'(FILTER_CYCLES);

    logic [WIDTH-1:0] filt_q, filt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            filt_q <= '0;
            pend_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            pend_q <= pend_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        pend_d = pend_q;
        fcnt_d = fcnt_q;
        if (decouple_i || sync2_q == filt_q) begin
            fcnt_d = '0;
        end else begin
            // A different candidate restarts the stability count
            if (fcnt_q == '0 || sync2_q != pend_q) begin
                pend_d = sync2_q;
                fcnt_d = FW'(1);
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
            if (fcnt_d == FCNT_DONE) begin
                filt_d = sync2_q;
                fcnt_d = '0;
            end
        end
    end

    assign eval_val = filt_q;
`else
    assign eval_val = sync2_q;
`endif

    // -------------------------------------------------------------------------
    // Value classification
    // -------------------------------------------------------------------------
    state_t           state_q, state_d;
    cand_t            cand_q, cand_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             lock_right_q, lock_right_d;
    logic [3:0]       pos_q, pos_d;
    logic [15:0]      step_cnt_q, step_cnt_d;

    logic             locked_q, locked_d;
    logic             dir_right_q, dir_right_d;
    logic             dir_left_q, dir_left_d;
    logic             stalled_q, stalled_d;
    logic             fault_q, fault_d;

    logic             changed;
    logic             legal;
    logic             r_step;
    logic             l_step;
    logic             cand_ok;
    logic             locked_step;
    logic [3:0]       eval_idx;

    assign changed = (eval_val != prev_q);
    assign legal   = $onehot(eval_val);

    // R and L can never both hold for a legal value because WIDTH >= 3
    assign r_step = changed && legal &&
                    ((eval_val == (prev_q >> 1)) ||
                     (prev_q == LED_LSB && eval_val == LED_MSB));
    assign l_step = changed && legal &&
                    ((eval_val == (prev_q << 1)) ||
                     (prev_q == LED_MSB && eval_val == LED_LSB));

    assign cand_ok     = (r_step && cand_q != C_LEFT) || (l_step && cand_q != C_RIGHT);
    assign locked_step = (r_step && lock_right_q) || (l_step && !lock_right_q);

    always_comb begin
        eval_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (eval_val[i]) begin
                eval_idx = 4'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q      <= S_IDLE;
            cand_q       <= C_NONE;
            prev_q       <= '0;
            run_q        <= '0;
            tmo_q        <= '0;
            lock_right_q <= 1'b0;
            pos_q        <= '0;
            step_cnt_q   <= '0;
            locked_q     <= 1'b0;
            dir_right_q  <= 1'b0;
            dir_left_q   <= 1'b0;
            stalled_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            tmo_q        <= tmo_d;
            lock_right_q <= lock_right_d;
            pos_q        <= pos_d;
            step_cnt_q   <= step_cnt_d;
            locked_q     <= locked_d;
            dir_right_q  <= dir_right_d;
            dir_left_q   <= dir_left_d;
            stalled_q    <= stalled_d;
            fault_q      <= fault_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        prev_d       = prev_q;
        run_d        = run_q;
        tmo_d        = tmo_q;
        lock_right_d = lock_right_q;
        pos_d        = pos_q;
        step_cnt_d   = step_cnt_q;

        if (decouple_i) begin
            // Decouple overrides any step arriving in the same cycle
            state_d      = S_IDLE;
            cand_d       = C_NONE;
            prev_d       = '0;
            run_d        = '0;
            tmo_d        = '0;
            lock_right_d = 1'b0;
            pos_d        = '0;
            step_cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (changed && legal) begin
                        state_d = S_TRACK;
                        prev_d  = eval_val;
                        pos_d   = eval_idx;
                        cand_d  = C_NONE;
                        run_d   = '0;
                    end
                end

                S_TRACK: begin
                    if (changed) begin
                        if (!legal) begin
                            state_d = S_FAULT;
                        end else begin
                            prev_d = eval_val;
                            pos_d  = eval_idx;
                            if (cand_ok) begin
                                cand_d = r_step ? C_RIGHT : C_LEFT;
                                run_d  = run_q + 1'b1;
                                if (run_d == RUN_LOCK) begin
                                    state_d      = S_LOCKED;
                                    lock_right_d = r_step;
                                    step_cnt_d   = '0;
                                    tmo_d        = '0;
                                    run_d        = '0;
                                end
                            end else begin
                                // Non-step jump or reversal restarts the run here
                                cand_d = C_NONE;
                                run_d  = '0;
                            end
                        end
                    end
                end

                S_LOCKED, S_STALL: begin
                    if (changed) begin
                        if (locked_step) begin
                            state_d = S_LOCKED;
                            prev_d  = eval_val;
                            pos_d   = eval_idx;
                            tmo_d   = '0;
                            if (step_cnt_q != '1) begin
                                step_cnt_d = step_cnt_q + 16'd1;
                            end
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else if (state_q == S_LOCKED) begin
                        if (tmo_q != TMO_MAX) begin
                            tmo_d = tmo_q + 1'b1;
                        end
                        if (tmo_d == TMO_MAX) begin
                            state_d = S_STALL;
                        end
                    end
                end

                S_FAULT: begin
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output logic (decoded from the next state, then registered)
    // -------------------------------------------------------------------------
    always_comb begin
        locked_d    = (state_d == S_LOCKED) || (state_d == S_STALL);
        dir_right_d = locked_d && lock_right_d;
        dir_left_d  = locked_d && !lock_right_d;
        stalled_d   = (state_d == S_STALL);
        fault_d     = (state_d == S_FAULT);
    end

    assign locked_o    = locked_q;
    assign dir_right_o = dir_right_q;
    assign dir_left_o  = dir_left_q;
    assign stalled_o   = stalled_q;
    assign fault_o     = fault_q;
    assign pos_o       = pos_q;
    assign step_cnt_o  = step_cnt_q;

endmodule

// File: tb/tb_led_pattern_monitor.sv
module tb_led_pattern_monitor;

    localparam int T = 100;
    localparam int F = 4;
`ifdef LED_MON_GLITCH_FILTER_EN
    localparam int LAT = 3 + F;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        decouple = 1'b0;
    logic [15:0] led = '0;
    logic        locked, dir_right, dir_left, stalled, fault;
    logic [3:0]  pos;
    logic [15:0] step_cnt;

    always #5 clk = ~clk;

    led_pattern_monitor #(
        .WIDTH        (16),
        .LOCK_STEPS   (4),
        .TICK_TIMEOUT (T),
        .FILTER_CYCLES(F)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .led_in_i   (led),
        .decouple_i (decouple),
        .locked_o   (locked),
        .dir_right_o(dir_right),
        .dir_left_o (dir_left),
        .stalled_o  (stalled),
        .fault_o    (fault),
        .pos_o      (pos),
        .step_cnt_o (step_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Value-level reference model
    typedef enum int {M_IDLE, M_TRACK, M_LOCK, M_STALL, M_FAULT} mode_t;
    mode_t m_mode;
    int m_prev, m_cand, m_run, m_dir, m_pos, m_cnt;
    logic [15:0] cur;

    function automatic int idx_of(input int v);
        for (int i = 0; i < 16; i++) if (v == (1 << i)) return i;
        return 0;
    endfunction

    function automatic logic [15:0] rot_r(input logic [15:0] v);
        return (v == 16'h0001) ? 16'h8000 : (v >> 1);
    endfunction

    function automatic logic [15:0] rot_l(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h0001 : (v << 1);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_prev = 0; m_cand = 0; m_run = 0; m_dir = 0; m_pos = 0; m_cnt = 0;
    endtask

    task automatic model_apply(input int v);
        bit legal;
        int d;
        legal = ($countones(v) == 1);
        d = 0;
        if (v == m_prev) return;
        if (legal && m_prev != 0 && (v * 2 == m_prev || (m_prev == 1 && v == 32768))) d = 1;
        else if (legal && m_prev != 0 && (v == m_prev * 2 || (m_prev == 32768 && v == 1))) d = -1;
        case (m_mode)
            M_IDLE: if (legal) begin
                m_mode = M_TRACK; m_prev = v; m_pos = idx_of(v); m_cand = 0; m_run = 0;
            end
            M_TRACK: if (!legal) m_mode = M_FAULT;
            else begin
                m_prev = v; m_pos = idx_of(v);
                if (d != 0 && (m_cand == 0 || m_cand == d)) begin
                    m_cand = d; m_run++;
                    if (m_run == 4) begin m_mode = M_LOCK; m_dir = d; m_cnt = 0; end
                end else begin
                    m_cand = 0; m_run = 0;
                end
            end
            M_LOCK, M_STALL: if (d != 0 && d == m_dir) begin
                m_mode = M_LOCK; m_prev = v; m_pos = idx_of(v);
                if (m_cnt < 65535) m_cnt++;
            end else m_mode = M_FAULT;
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit lk;
        lk = (m_mode == M_LOCK || m_mode == M_STALL);
        chk({tag, ".locked"},    locked,    32'(lk));
        chk({tag, ".dir_right"}, dir_right, 32'(lk && m_dir == 1));
        chk({tag, ".dir_left"},  dir_left,  32'(lk && m_dir == -1));
        chk({tag, ".stalled"},   stalled,   32'(m_mode == M_STALL));
        chk({tag, ".fault"},     fault,     32'(m_mode == M_FAULT));
        chk({tag, ".pos"},       pos,       32'(m_pos));
        chk({tag, ".step_cnt"},  step_cnt,  32'(m_cnt));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".locked"},    locked,    0);
        chk({tag, ".dir_right"}, dir_right, 0);
        chk({tag, ".dir_left"},  dir_left,  0);
        chk({tag, ".stalled"},   stalled,   0);
        chk({tag, ".fault"},     fault,     0);
        chk({tag, ".pos"},       pos,       0);
        chk({tag, ".step_cnt"},  step_cnt,  0);
    endtask

    // Drive v for h cycles; checks old outputs one cycle before the latency
    // point, new outputs at it, the exact stall edge, and the settled outputs.
    task automatic hold(input logic [15:0] v, input int h);
        led = v;
        cur = v;
        repeat (LAT - 1) @(negedge clk);
        check_all("hold_pre");
        model_apply(int'(v));
        @(negedge clk);
        check_all("hold_post");
        if (m_mode == M_LOCK && h > LAT + T) begin
            repeat (T - 1) @(negedge clk);
            chk("stall_before", stalled, 0);
            @(negedge clk);
            m_mode = M_STALL;
            check_all("stall_edge");
            repeat (h - LAT - T) @(negedge clk);
        end else begin
            repeat (h - LAT) @(negedge clk);
        end
        check_all("hold_end");
    endtask

    task automatic do_decouple();
        decouple = 1'b1;
        @(negedge clk);
        check_zero("decouple");
        decouple = 1'b0;
        model_reset();
        model_apply(int'(cur));
        repeat (20) @(negedge clk);
        check_all("decouple_settle");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_apply(int'(cur));
        repeat (20) @(negedge clk);
        check_all("reset_settle");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, h, pref;
        logic [15:0] nv;

        model_reset();
        cur = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Lock to shift-right
        hold(16'h8000, 20); hold(16'h4000, 20); hold(16'h2000, 20);
        hold(16'h1000, 20); hold(16'h0800, 20);
        chk("s1_locked", locked, 1);
        chk("s1_dir_right", dir_right, 1);
        chk("s1_pos", pos, 11);
        chk("s1_step_cnt", step_cnt, 0);

        // Keep stepping right through the wrap to 0x8000
        while (cur != 16'h8000) hold(rot_r(cur), 20);
        chk("s2_step_cnt", step_cnt, 12);
        chk("s2_pos", pos, 15);
        chk("s2_fault", fault, 0);

        // Lock to shift-left, then reverse
        do_decouple();
        hold(16'h2000, 20); hold(16'h4000, 20); hold(16'h8000, 20);
        hold(16'h0001, 20); hold(16'h0002, 20);
        chk("s3_locked", locked, 1);
        chk("s3_dir_left", dir_left, 1);
        chk("s3_pos", pos, 1);
        hold(16'h0001, 20);
        chk("s3_fault", fault, 1);
        chk("s3_locked_off", locked, 0);
        chk("s3_pos_hold", pos, 1);

        // Illegal value while locked; fault is sticky
        do_decouple();
        hold(16'h8000, 20); hold(16'h4000, 20); hold(16'h2000, 20); hold(16'h1000, 20);
        chk("s4_locked", locked, 1);
        hold(16'h0003, 20);
        chk("s4_fault", fault, 1);
        hold(16'h0800, 20);
        chk("s4_fault_sticky", fault, 1);
        chk("s4_pos_hold", pos, 12);
        do_decouple();

        // Stall and recovery
        hold(16'h0400, 20); hold(16'h0200, 20); hold(16'h0100, 20); hold(16'h0080, 20);
        hold(16'h0040, 150);
        chk("s5_stalled", stalled, 1);
        chk("s5_locked", locked, 1);
        chk("s5_step_cnt", step_cnt, 1);
        hold(16'h0020, 20);
        chk("s5_unstalled", stalled, 0);
        chk("s5_step_cnt2", step_cnt, 2);

        // Decouple coincident with a step being evaluated
        do_decouple();
        led = 16'h0010;
        cur = 16'h0010;
        repeat (LAT - 1) @(negedge clk);
        decouple = 1'b1;
        @(negedge clk);
        check_zero("s6_dec_step");
        decouple = 1'b0;
        model_reset();
        model_apply(int'(cur));
        repeat (20) @(negedge clk);
        check_all("s6_dec_settle");
        chk("s6_locked", locked, 0);

        // One-cycle glitch while locked
        hold(16'h0008, 20); hold(16'h0004, 20); hold(16'h0002, 20); hold(16'h0001, 20);
        chk("s6_relocked", locked, 1);
        led = 16'h8000;
        @(negedge clk);
        led = 16'h0001;
`ifndef LED_MON_GLITCH_FILTER_EN
        model_apply(32'h8000);
        model_apply(32'h0001);
`endif
        repeat (20) @(negedge clk);
        check_all("glitch");
`ifdef LED_MON_GLITCH_FILTER_EN
        chk("glitch_fault", fault, 0);
`else
        chk("glitch_fault", fault, 1);
`endif

        // Reset mid-operation
        do_reset();

        // Randomized traffic
        pref = 1;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            h = ($urandom_range(0, 99) < 6) ? 150 : 20;
            if (r < 6) begin
                do_decouple();
                pref = $urandom_range(0, 1);
            end else if (r < 9) begin
                do_reset();
            end else begin
                if (r < 75 && $countones(cur) == 1) begin
                    nv = pref ? rot_r(cur) : rot_l(cur);
                end else if (r < 80 && $countones(cur) == 1) begin
                    nv = pref ? rot_l(cur) : rot_r(cur);
                end else if (r < 90) begin
                    do nv = 16'(1 << $urandom_range(0, 15)); while (nv == cur);
                end else begin
                    do nv = 16'($urandom_range(0, 65535));
                    while ($countones(nv) == 1 || nv == cur);
                end
                hold(nv, h);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
